// File: rtl/seq_mini_alu.sv
// Multi-cycle mini ALU with valid/ready handshakes: single-cycle ADD/SUB/logic,
// iterative shift-add MUL and restoring DIV/REM. Define SEQ_ALU_FAST_MUL_EN for a one-cycle MUL.
module seq_mini_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             out_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // out_data/out_err/out_zero stay stable while out_valid is high and out_ready is low.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_REM = 4'd7;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  // MUL: acc = running product, sh_a = shifted multiplicand, sh_b = multiplier (LSB first).
  // DIV/REM: acc = partial remainder, sh_a = dividend shifting into quotient, sh_b = divisor.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;

  logic [WIDTH-1:0] fast_res;
  logic             fast_err;
  logic             is_iter;

  logic [WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] iter_res;
  logic             iter_err;

  assign in_ready  = (state == S_IDLE) && en;
  assign out_valid = (state == S_DONE);

  always_comb begin
    fast_res = '0;
    fast_err = 1'b0;
    is_iter  = 1'b0;
    case (in_op)
      OP_ADD: fast_res = in_a + in_b;
      OP_SUB: fast_res = in_a - in_b;
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL: fast_res = in_a * in_b;
`else
      OP_MUL: is_iter = 1'b1;
`endif
      OP_DIV: is_iter = 1'b1;
      OP_AND: fast_res = in_a & in_b;
      OP_OR:  fast_res = in_a | in_b;
      OP_XOR: fast_res = in_a ^ in_b;
      OP_REM: is_iter = 1'b1;
      default: fast_err = 1'b1;
    endcase
  end

  always_comb begin
    mul_acc_nx = acc + (sh_b[0] ? sh_a : '0);
    rem_sh     = {acc, sh_a[WIDTH-1]};
    rem_sub    = rem_sh - {1'b0, sh_b};
    // No borrow means the shifted remainder was >= divisor; b == 0 therefore
    // yields an all-ones quotient and a remainder equal to the dividend.
    div_ge     = !rem_sub[WIDTH];
    rem_nx     = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx     = {sh_a[WIDTH-2:0], div_ge};
    iter_res   = '0;
    case (op_q)
      OP_MUL:  iter_res = mul_acc_nx;
      OP_DIV:  iter_res = quo_nx;
      OP_REM:  iter_res = rem_nx;
      default: iter_res = '0;
    endcase
    iter_err = (op_q != OP_MUL) && (sh_b == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      acc      <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
      out_zero <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && en) begin
            op_q <= in_op;
            if (is_iter) begin
              state <= S_BUSY;
              cnt   <= CNT_W'(WIDTH);
              acc   <= '0;
              sh_a  <= in_a;
              sh_b  <= in_b;
            end else begin
              state    <= S_DONE;
              out_data <= fast_res;
              out_err  <= fast_err;
              out_zero <= (fast_res == '0);
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (op_q == OP_MUL) begin
            acc  <= mul_acc_nx;
            sh_a <= sh_a << 1;
            sh_b <= sh_b >> 1;
          end else begin
            acc  <= rem_nx;
            sh_a <= quo_nx;
          end
          if (cnt == CNT_W'(1)) begin
            state    <= S_DONE;
            out_data <= iter_res;
            out_err  <= iter_err;
            out_zero <= (iter_res == '0);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_mini_alu.md
Name: seq_mini_alu

Overview:
Parametrised, multi-cycle successor to the combinational mini ALU used on the jump/branch address path.
- Adds a valid/ready handshake on the operand and result sides.
- Runs iterative shift-add multiply and restoring divide, with unsigned remainder and error/zero flags.
- Sits between the decode stage and the jump-target/branch logic and accepts one operation at a time.

Parameters:
WIDTH, 32, operand/result width in bits; minimum 2.
CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  enable (JMP_ENB equivalent); gates acceptance only.
in_valid  in  1  operand/op present.
in_ready  out  1  block can accept an operation.
in_op  in  4  operation code.
in_a  in  WIDTH  operand 1 (dividend/minuend).
in_b  in  WIDTH  operand 2 (divisor/subtrahend).
out_valid  out  1  result present.
out_ready  in  1  consumer takes result.
out_data  out  WIDTH  result.
out_err  out  1  invalid opcode or divide-by-zero.
out_zero  out  1  out_data == 0.

Behaviour:
- Reset: state=IDLE, counter=0, out_valid=0, out_data=0, out_err=0, out_zero=1. While rst is high it overrides all other inputs. Reset mid-operation abandons the operation with no output.
- States:
  - IDLE: in_ready = en. If in_valid && en, latch op/operands.
    - Single-cycle ops go to DONE.
    - MUL/DIV/REM go to BUSY with counter=WIDTH.
  - BUSY: one iteration per edge, counter decrements. On the edge where counter==1, write the result and go to DONE.
  - DONE: out_valid=1 and outputs stable. On out_valid && out_ready, go to IDLE and drop out_valid.
- in_ready is 0 in BUSY and DONE. Maximum throughput is one single-cycle op per 2 clocks.
- Latency from the acceptance edge k to out_valid:
  - Single-cycle ops: after edge k+1... precisely, out_valid is visible after edge k.
  - MUL/DIV/REM: out_valid is visible after edge k+WIDTH.
- en low: no new acceptance. An in-flight BUSY/DONE operation completes unaffected.
- Opcodes, all unsigned and modulo 2^WIDTH:
  - 0 ADD: a+b, carry discarded.
  - 1 SUB: a-b, wraps.
  - 2 MUL: low WIDTH bits of a*b.
  - 3 DIV: floor(a/b).
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 REM: a mod b.
  - 8-15: out_data=0, out_err=1, single-cycle.
- Divide-by-zero (op 3/7 with b==0):
  - Full WIDTH-cycle latency is preserved.
  - DIV result = all ones; REM result = a; out_err=1.
- out_err=0 for every other case.
- out_zero is registered together with out_data.
- Inputs not sampled outside the acceptance edge are don't-care. Operands are held internally, so in_a/in_b may change after acceptance.
- MUL: shift-add over b, LSB first.
- DIV/REM: restoring, MSB first, with a (WIDTH+1)-bit partial remainder.

Optional Feature:
SEQ_ALU_FAST_MUL_EN:
- Defined: MUL (op 2) uses a single-cycle combinational multiplier and is treated as a single-cycle op (latency 1). DIV/REM are unchanged.
- Undefined: MUL is iterative with WIDTH-cycle latency as above.
- Results are bit-identical either way.

Test Plan:
- WIDTH=32, en=1, ADD a=7 b=5, out_ready=1 → out_valid one edge after acceptance, out_data=12, out_err=0, out_zero=0.
- DIV a=100 b=7, then REM a=100 b=7 → out_data=14, then 2. Each arrives exactly 32 edges after acceptance; in_ready=0 throughout BUSY.
- DIV a=0x1234 b=0 → out_data=0xFFFFFFFF, out_err=1. REM a=0x1234 b=0 → out_data=0x1234, out_err=1.
- SUB a=3 b=3 with out_ready held low 10 cycles → out_data=0, out_zero=1, held stable. Released on the first out_ready edge, then in_ready=1 the next cycle.
- MUL a=0xFFFFFFFF b=2, rst pulsed 10 cycles after acceptance → no out_valid, outputs return to reset values. A fresh MUL a=6 b=7 then yields 42.
- Opcode 9 → out_data=0, out_err=1 after 1 edge. With en=0 and in_valid=1, in_ready stays 0 and nothing is accepted.
